pu_msp430_ram_bist: RTL



---
 rtl/pu_msp430_ram_bist_pkg.sv | 51 +++++
 rtl/pu_msp430_ram_bist_if.sv | 13 +
 rtl/pu_msp430_ram_bist_addr_cnt.sv | 44 ++++
 rtl/pu_msp430_ram_bist.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pu_msp430_ram_bist_pkg.sv
// Shared types and March C- tables for the MSP430 RAM BIST initiator.
package pu_msp430_ram_bist_pkg;

    // Controller states; WR/RD/CMPWR/RDP/LAST own the RAM port.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_CMPWR = 3'd3,
        S_RDP   = 3'd4,
        S_LAST  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // March element indices.
    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    // Background patterns.
    localparam logic [15:0] P0 = 16'h0000;
    localparam logic [15:0] P1 = 16'hFFFF;

    // Address direction of an element: 1 = descending (W-1 down to 0).
    function automatic logic elem_down(input logic [2:0] e);
        case (e)
            E3, E4:  elem_down = 1'b1;
            default: elem_down = 1'b0;
        endcase
    endfunction

    // Value every read of an element must return.
    function automatic logic [15:0] elem_exp(input logic [2:0] e);
        case (e)
            E2, E4:  elem_exp = P1;
            default: elem_exp = P0;
        endcase
    endfunction

    // Value written by an element (E5 is read-only; its entry is unused).
    function automatic logic [15:0] elem_wr(input logic [2:0] e);
        case (e)
            E1, E3:  elem_wr = P1;
            default: elem_wr = P0;
        endcase
    endfunction

endpackage

// File: rtl/pu_msp430_ram_bist_if.sv
// Single-port RAM bus between the BIST initiator (master) and the RAM (slave).
interface pu_msp430_ram_bist_if #(
    parameter int ADDR_MSB = 6
);
    logic [ADDR_MSB:0] ram_addr;
    logic              ram_cen;
    logic [1:0]        ram_wen;
    logic [15:0]       ram_din;
    logic [15:0]       ram_dout;

    modport master (output ram_addr, ram_cen, ram_wen, ram_din, input ram_dout);
    modport slave  (input ram_addr, ram_cen, ram_wen, ram_din, output ram_dout);
endinterface

// File: rtl/pu_msp430_ram_bist_addr_cnt.sv
// Word address counter for the March walk: loads to 0 or W-1, steps up or
// down, and never leaves the range 0..W-1.
module pu_msp430_ram_bist_addr_cnt #(
    parameter int ADDR_MSB = 6,
    parameter int W        = 128
) (
    input  logic              mclk,
    input  logic              puc_rst_n,
    input  logic              i_load_lo,
    input  logic              i_load_hi,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [ADDR_MSB:0] o_cnt,
    output logic              o_at_hi,
    output logic              o_at_lo
);
    localparam int                AW  = ADDR_MSB + 1;
    localparam logic [ADDR_MSB:0] HI  = AW'(W - 1);
    localparam logic [ADDR_MSB:0] ONE = AW'(1);

    logic [ADDR_MSB:0] r_cnt;

    // Address register: loads win over stepping, steps saturate at the ends.
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            r_cnt <= '0;
        end else if (i_load_lo) begin
            r_cnt <= '0;
        end else if (i_load_hi) begin
            r_cnt <= HI;
        end else if (i_inc && (r_cnt != HI)) begin
            r_cnt <= r_cnt + ONE;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_at_hi = (r_cnt == HI);
    assign o_at_lo = (r_cnt == '0);

endmodule

// File: rtl/pu_msp430_ram_bist.sv
// March C- built-in self-test initiator for the MSP430 single-port RAM.
// Owns the RAM port while busy, checks registered read data and records the
// first failing word address and March element.
module pu_msp430_ram_bist
    import pu_msp430_ram_bist_pkg::*;
#(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    input  logic                    bist_start,
    output logic                    bist_busy,
    output logic                    bist_done,
    output logic                    bist_fail,
    output logic [ADDR_MSB:0]       bist_fail_addr,
    output logic [2:0]              bist_fail_elem,
    pu_msp430_ram_bist_if.master    bus
);
    localparam int                W   = MEM_SIZE / 2;
    localparam int                AW  = ADDR_MSB + 1;
    localparam logic [ADDR_MSB:0] ONE = AW'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_elem;
    logic [2:0]        w_elem_nxt;
    logic [2:0]        w_elem_inc;
    logic              r_done;
    logic              r_fail;
    logic [ADDR_MSB:0] r_fail_addr;
    logic [2:0]        r_fail_elem;

    logic [ADDR_MSB:0] w_cnt;
    logic              w_at_hi;
    logic              w_at_lo;
    logic              w_load_lo;
    logic              w_load_hi;
    logic              w_inc;
    logic              w_dec;
    logic              w_busy;
    logic              w_mismatch;
    logic              w_elem_end;
    logic              w_clr;
    logic              w_set_done;
    logic              w_set_fail;
    logic [ADDR_MSB:0] w_fail_addr_nxt;
    logic              w_cen;
    logic [1:0]        w_wen;
    logic [15:0]       w_din;

    pu_msp430_ram_bist_addr_cnt #(
        .ADDR_MSB (ADDR_MSB),
        .W        (W)
    ) u_addr_cnt (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .i_load_lo (w_load_lo),
        .i_load_hi (w_load_hi),
        .i_inc     (w_inc),
        .i_dec     (w_dec),
        .o_cnt     (w_cnt),
        .o_at_hi   (w_at_hi),
        .o_at_lo   (w_at_lo)
    );

    assign w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_mismatch = (bus.ram_dout != elem_exp(r_elem));
    assign w_elem_inc = r_elem + 3'd1;
    assign w_elem_end = elem_down(r_elem) ? w_at_lo : w_at_hi;

    // Next-state, counter control, RAM port drive and result updates.
    always_comb begin
        w_state_nxt     = r_state;
        w_elem_nxt      = r_elem;
        w_load_lo       = 1'b0;
        w_load_hi       = 1'b0;
        w_inc           = 1'b0;
        w_dec           = 1'b0;
        w_clr           = 1'b0;
        w_set_done      = 1'b0;
        w_set_fail      = 1'b0;
        w_fail_addr_nxt = w_cnt;
        w_cen           = 1'b1;
        w_wen           = 2'b11;
        w_din           = P0;
        case (r_state)
            S_IDLE: begin
                if (bist_start) begin
                    w_state_nxt = S_WR;
                    w_elem_nxt  = E0;
                    w_load_lo   = 1'b1;
                    w_clr       = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WR: begin
                w_cen = 1'b0;
                w_wen = 2'b00;
                w_din = elem_wr(r_elem);
                if (w_at_hi) begin
                    w_state_nxt = S_RD;
                    w_elem_nxt  = E1;
                    w_load_lo   = 1'b1;
                end else begin
                    w_inc = 1'b1;
                end
            end
            S_RD: begin
                w_cen       = 1'b0;
                w_state_nxt = S_CMPWR;
            end
            S_CMPWR: begin
                if (w_mismatch) begin
                    // Abort without touching the failing word again.
                    w_set_fail  = 1'b1;
                    w_set_done  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cen = 1'b0;
                    w_wen = 2'b00;
                    w_din = elem_wr(r_elem);
                    if (w_elem_end) begin
                        w_elem_nxt = w_elem_inc;
                        if (r_elem == E4) begin
                            w_state_nxt = S_RDP;
                            w_load_lo   = 1'b1;
                        end else begin
                            w_state_nxt = S_RD;
                            if (elem_down(w_elem_inc)) begin
                                w_load_hi = 1'b1;
                            end else begin
                                w_load_lo = 1'b1;
                            end
                        end
                    end else begin
                        w_state_nxt = S_RD;
                        if (elem_down(r_elem)) begin
                            w_dec = 1'b1;
                        end else begin
                            w_inc = 1'b1;
                        end
                    end
                end
            end
            S_RDP: begin
                // Read of address a overlaps the check of address a-1.
                if (!w_at_lo && w_mismatch) begin
                    w_set_fail      = 1'b1;
                    w_set_done      = 1'b1;
                    w_fail_addr_nxt = w_cnt - ONE;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cen = 1'b0;
                    if (w_at_hi) begin
                        w_state_nxt = S_LAST;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            S_LAST: begin
                w_set_fail  = w_mismatch;
                w_set_done  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state and current element.
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            r_state <= S_IDLE;
            r_elem  <= E0;
        end else begin
            r_state <= w_state_nxt;
            r_elem  <= w_elem_nxt;
        end
    end

    // Sticky result flags: cleared on an accepted start, set on completion.
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
        end else if (w_clr) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
        end else begin
            if (w_set_done) begin
                r_done <= 1'b1;
            end
            if (w_set_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= w_fail_addr_nxt;
                r_fail_elem <= r_elem;
            end
        end
    end

    assign bist_busy      = w_busy;
    assign bist_done      = r_done;
    assign bist_fail      = r_fail;
    assign bist_fail_addr = r_fail_addr;
    assign bist_fail_elem = r_fail_elem;

    assign bus.ram_addr = w_busy ? w_cnt : '0;
    assign bus.ram_cen  = w_cen;
    assign bus.ram_wen  = w_wen;
    assign bus.ram_din  = w_din;

endmodule
